// File: rtl/mul8_char_pkg.sv
// -----------------------------------------------------------------------------
// mul8_char_pkg
// Shared definitions for the approximate-multiplier characterisation stage:
// default operand width, sweep FSM states, accumulator widths and a 16-bit
// population count used for the Hamming-distance statistic.
// -----------------------------------------------------------------------------
package mul8_char_pkg;

  // Default operand width; product is twice this wide.
  localparam int OW_DEF = 8;

  // ERR_SUM is fixed at 32 bits: 65536 * 65535 still fits for OW = 8.
  localparam int ERR_SUM_W = 32;
  // ERR_CNT needs one bit beyond the product width to hold 2^(2*OW).
  localparam int ERR_CNT_EXTRA_W = 1;
  // HD_SUM needs five bits beyond the product width (up to 16 per pair).
  localparam int HD_SUM_EXTRA_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [4:0] popcount16(input logic [15:0] x);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, x[i]};
    end
    return n;
  endfunction

endpackage : mul8_char_pkg

// File: rtl/mul8_err_acc.sv
// -----------------------------------------------------------------------------
// mul8_err_acc
// Error datapath behind the S1 operand/product register: computes the exact
// product, absolute error, Hamming distance and mismatch flag into S2, then
// accumulates them into the running statistics.
//
// Ports
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   clear_i      start-of-sweep clear (same effect as reset on this block)
//   v1_i         S1 valid
//   a_i, b_i     S1 operands
//   o_i          S1 approximate product
//   err_sum_o    sum of absolute errors
//   err_max_o    largest absolute error seen
//   err_max_a_o  A of the first pair reaching err_max_o
//   err_max_b_o  B of the first pair reaching err_max_o
//   err_cnt_o    number of pairs with a non-zero error
//   hd_sum_o     sum of Hamming distances
// -----------------------------------------------------------------------------
module mul8_err_acc
  import mul8_char_pkg::*;
#(
  parameter int OW = OW_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          v1_i,
  input  logic [OW-1:0]                 a_i,
  input  logic [OW-1:0]                 b_i,
  input  logic [2*OW-1:0]               o_i,
  output logic [ERR_SUM_W-1:0]          err_sum_o,
  output logic [2*OW-1:0]               err_max_o,
  output logic [OW-1:0]                 err_max_a_o,
  output logic [OW-1:0]                 err_max_b_o,
  output logic [2*OW+ERR_CNT_EXTRA_W-1:0] err_cnt_o,
  output logic [2*OW+HD_SUM_EXTRA_W-1:0]  hd_sum_o
);

  localparam int PW    = 2 * OW;
  localparam int CNT_W = PW + ERR_CNT_EXTRA_W;
  localparam int HD_W  = PW + HD_SUM_EXTRA_W;

  // S2 next-state values
  logic [PW-1:0] exact_d;
  logic [PW-1:0] aerr_d;
  logic [4:0]    hd_d;
  logic          ne_d;

  // S2 registers
  logic          v2_q;
  logic [PW-1:0] aerr_q;
  logic [4:0]    hd_q;
  logic          ne_q;
  logic [OW-1:0] a2_q;
  logic [OW-1:0] b2_q;

  // Accumulators
  logic [ERR_SUM_W-1:0] err_sum_q;
  logic [PW-1:0]        err_max_q;
  logic [OW-1:0]        err_max_a_q;
  logic [OW-1:0]        err_max_b_q;
  logic [CNT_W-1:0]     err_cnt_q;
  logic [HD_W-1:0]      hd_sum_q;

  // NOTE: every variable assigned in an always_comb gets a value on every
  // path; here that holds trivially, and it is what keeps latches out.
  always_comb begin
    exact_d = PW'(a_i) * PW'(b_i);
    aerr_d  = (exact_d >= o_i) ? (exact_d - o_i) : (o_i - exact_d);
    // Product width never exceeds 16 bits for the supported OW range.
    hd_d    = popcount16(16'(exact_d ^ o_i));
    ne_d    = (aerr_d != '0);
  end

  // NOTE: reset is sampled on the clock edge, and the start-of-sweep clear
  // shares that branch so a new sweep begins from exactly the reset state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      v2_q        <= 1'b0;
      aerr_q      <= '0;
      hd_q        <= '0;
      ne_q        <= 1'b0;
      a2_q        <= '0;
      b2_q        <= '0;
      err_sum_q   <= '0;
      err_max_q   <= '0;
      err_max_a_q <= '0;
      err_max_b_q <= '0;
      err_cnt_q   <= '0;
      hd_sum_q    <= '0;
    end else begin
      v2_q   <= v1_i;
      aerr_q <= aerr_d;
      hd_q   <= hd_d;
      ne_q   <= ne_d;
      a2_q   <= a_i;
      b2_q   <= b_i;
      if (v2_q) begin
        err_sum_q <= err_sum_q + ERR_SUM_W'(aerr_q);
        err_cnt_q <= err_cnt_q + CNT_W'(ne_q);
        hd_sum_q  <= hd_sum_q + HD_W'(hd_q);
        // Strictly greater: on a tie the earlier pair in sweep order stays.
        if (aerr_q > err_max_q) begin
          err_max_q   <= aerr_q;
          err_max_a_q <= a2_q;
          err_max_b_q <= b2_q;
        end
      end
    end
  end

  assign err_sum_o   = err_sum_q;
  assign err_max_o   = err_max_q;
  assign err_max_a_o = err_max_a_q;
  assign err_max_b_o = err_max_b_q;
  assign err_cnt_o   = err_cnt_q;
  assign hd_sum_o    = hd_sum_q;

endmodule : mul8_err_acc

// File: rtl/mul8_err_monitor.sv
// -----------------------------------------------------------------------------
// mul8_err_monitor
// Exhaustive characterisation wrapper for a combinational OWxOW approximate
// multiplier. Sweeps every operand pair (B-major, A-minor), registers each
// returned product with its operands (S1) and hands them to mul8_err_acc,
// which builds the error statistics.
//
// Ports
//   CLK          clock
//   RST_N        synchronous active-low reset
//   START        begin a sweep (honoured in IDLE or DONE only)
//   A_OUT/B_OUT  operands to the multiplier (low/high half of the counter)
//   O_IN         approximate product for A_OUT/B_OUT, same cycle
//   BUSY         sweep or pipeline drain in progress
//   DONE         sweep complete, statistics final and held
//   ERR_SUM, ERR_MAX, ERR_MAX_A, ERR_MAX_B, ERR_CNT, HD_SUM  statistics
// -----------------------------------------------------------------------------
module mul8_err_monitor
  import mul8_char_pkg::*;
#(
  parameter int OW = OW_DEF
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            START,
  output logic [OW-1:0]                   A_OUT,
  output logic [OW-1:0]                   B_OUT,
  input  logic [2*OW-1:0]                 O_IN,
  output logic                            BUSY,
  output logic                            DONE,
  output logic [ERR_SUM_W-1:0]            ERR_SUM,
  output logic [2*OW-1:0]                 ERR_MAX,
  output logic [OW-1:0]                   ERR_MAX_A,
  output logic [OW-1:0]                   ERR_MAX_B,
  output logic [2*OW+ERR_CNT_EXTRA_W-1:0] ERR_CNT,
  output logic [2*OW+HD_SUM_EXTRA_W-1:0]  HD_SUM
);

  localparam int PW = 2 * OW;

  state_e        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          drain_q, drain_d;   // second DRAIN cycle marker
  logic          start_ok;

  // S1 stage
  logic          v1_q;
  logic [OW-1:0] a1_q;
  logic [OW-1:0] b1_q;
  logic [PW-1:0] o1_q;

  assign start_ok = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {PW{1'b1}}) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Two cycles: one for S2 to fill, one for the accumulate.
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      o1_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      // Only pairs presented while in RUN are real sweep points; the
      // START-sampling edge sees IDLE/DONE, so this also clears v1.
      v1_q    <= (state_q == ST_RUN);
      a1_q    <= A_OUT;
      b1_q    <= B_OUT;
      o1_q    <= O_IN;
    end
  end

  assign A_OUT = cnt_q[OW-1:0];
  assign B_OUT = cnt_q[PW-1:OW];
  assign BUSY  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign DONE  = (state_q == ST_DONE);

  mul8_err_acc #(
    .OW (OW)
  ) u_acc (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .clear_i     (start_ok),
    .v1_i        (v1_q),
    .a_i         (a1_q),
    .b_i         (b1_q),
    .o_i         (o1_q),
    .err_sum_o   (ERR_SUM),
    .err_max_o   (ERR_MAX),
    .err_max_a_o (ERR_MAX_A),
    .err_max_b_o (ERR_MAX_B),
    .err_cnt_o   (ERR_CNT),
    .hd_sum_o    (HD_SUM)
  );

endmodule : mul8_err_monitor

// File: doc/mul8_err_monitor.md
# mul8_err_monitor

Self-checking characterisation stage for the 8x8 approximate multipliers. It drives every operand pair (A, B) exhaustively into a combinational approximate multiplier instance and consumes its 16-bit product in the same cycle. It compares each product against the exact product and accumulates error statistics: sum of absolute error (MAE numerator), worst-case error with the pair that caused it, error count (EP numerator) and Hamming-distance sum. It sits directly around the multiplier under test: upstream as the operand source, downstream as the product consumer.

## Interface
- `OW`, default 8: operand width. Product width is 2*OW; the sweep length is 2^(2*OW).
- `CLK` in 1: clock; all state changes on the rising edge.
- `RST_N` in 1: reset, synchronous, active-low.
- `START` in 1: one-cycle request to begin a sweep. Honoured only in IDLE or DONE.
- `A_OUT` out OW: operand A to the multiplier; equals `cnt[OW-1:0]`.
- `B_OUT` out OW: operand B to the multiplier; equals `cnt[2OW-1:OW]`.
- `O_IN` in 2OW: approximate product returned combinationally for `A_OUT`/`B_OUT`.
- `BUSY` out 1: high in RUN and DRAIN.
- `DONE` out 1: high in DONE; results are stable.
- `ERR_SUM` out 32: sum of |A*B - O_IN|.
- `ERR_MAX` out 2OW: maximum |A*B - O_IN|.
- `ERR_MAX_A` out OW: A operand of the first pair reaching `ERR_MAX`.
- `ERR_MAX_B` out OW: B operand of that same pair.
- `ERR_CNT` out 2OW+1: number of pairs with O_IN != A*B.
- `HD_SUM` out 2OW+5: sum of popcount(A*B xor O_IN).

## Operation
- States:
  - IDLE → RUN on START.
  - RUN → DRAIN when the pair with cnt = all-ones is captured.
  - DRAIN → DONE after 2 cycles.
  - DONE → RUN on START.
- Entering RUN, on the START-sampling edge:
  - cnt ← 0.
  - All accumulators, ERR_MAX_A and ERR_MAX_B ← 0.
  - Pipeline valids ← 0.
- Pipeline:
  - **S1:** registers {A_OUT, B_OUT, O_IN, v1}. v1 = 1 only in RUN.
  - **S2:** registers exact = A*B (unsigned, 2OW bits), aerr = |exact - O_IN|, hd = popcount(exact ^ O_IN), ne = (aerr != 0), plus A and B, and v2 = v1.
  - **ACC:** when v2 is set:
    - ERR_SUM += aerr.
    - ERR_CNT += ne.
    - HD_SUM += hd.
    - If aerr > ERR_MAX (strictly greater), then ERR_MAX ← aerr and {ERR_MAX_A, ERR_MAX_B} ← {A, B}.
- Tie rule: the earliest pair in sweep order wins. Sweep order is B-major, A-minor.
- Accumulators are sized so they never overflow for OW = 8. Worst-case ERR_SUM is 65536·65535 < 2^32.
- START while BUSY: ignored. There is no abort except reset.
- DONE holds all results until the next START or reset.
- Outputs stay valid but are not final while BUSY. Outputs update only in RUN/DRAIN.

## Timing
- Reset (RST_N low at an edge):
  - State ← IDLE; cnt and all outputs ← 0.
  - BUSY and DONE = 0.
  - Pipeline valids ← 0.
  - Reset mid-sweep discards everything; no partial results survive.
- Edge 0 samples START. Edge k+1 captures pair k into S1, for k = 0 … 2^(2OW)-1.
- The multiplier path, A_OUT/B_OUT → O_IN → S1, is a single-cycle combinational path.
- For OW = 8:
  - Last pair captured at edge 65536.
  - At edge 65538 the accumulators include it, state = DONE and DONE = 1.
  - BUSY is high from after edge 0 through edge 65538.
- START in the same cycle as RST_N low: reset wins.
- START sampled in DONE: the next sweep begins at that edge, and DONE drops the following cycle.

## Structure
- Shared package `mul8_char_pkg`:
  - `OW` default.
  - State enum {IDLE, RUN, DRAIN, DONE}.
  - Accumulator-width constants.
  - `popcount16` function.
- One natural sub-module, `mul8_err_acc`: the S2 + ACC datapath (error, Hamming distance, max-tracking, sums).
- The top level holds the FSM, the sweep counter and S1.
- The exact multiply uses the `*` operator. It is not an instance of an approximate cell.

## Test plan
- **Exact loopback** (O_IN = A_OUT*B_OUT) → ERR_SUM = 0, ERR_MAX = 0, ERR_CNT = 0, HD_SUM = 0, ERR_MAX_A/B = 0; DONE rises at edge 65538.
- **Stuck-zero multiplier** (O_IN = 0) → ERR_SUM = 1065369600, ERR_MAX = 65025, ERR_MAX_A = ERR_MAX_B = 255, ERR_CNT = 65025.
- **Off-by-one multiplier** (O_IN = A*B ^ 1) → ERR_SUM = 65536, ERR_MAX = 1, ERR_MAX_A = ERR_MAX_B = 0 (first pair, tie rule), ERR_CNT = 65536, HD_SUM = 65536.
- **START pulsed during RUN** at cycle 1000 → ignored; results identical to an uninterrupted sweep and DONE timing unchanged.
- **Reset mid-sweep** (RST_N low at cycle 30000, then START) → all outputs 0 after reset; the second sweep's results match the single-sweep reference.
- **Back-to-back:** START in DONE with O_IN switched from exact to stuck-zero → accumulators cleared at the START edge; final values equal those of the stuck-zero scenario.
